// File: rtl/mxv_dot_engine_if.sv
// Result-side handshake bundle for mxv_dot_engine.
//   master (engine): drives result, result_valid, row_idx; samples result_ready.
//   slave  (sink)  : samples result, result_valid, row_idx; drives result_ready.
interface mxv_dot_engine_if #(
  parameter int unsigned AccW = 19,
  parameter int unsigned RowW = 3
);
  logic [AccW-1:0] result;
  logic            result_valid;
  logic            result_ready;
  logic [RowW-1:0] row_idx;

  modport master (
    output result,
    output result_valid,
    output row_idx,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    input  row_idx,
    output result_ready
  );
endinterface

// File: rtl/mxv_dot_engine.sv
// Matrix-vector dot-product engine. Fetches Cols vector elements once into a local
// buffer, then for each of Rows rows pops Cols matrix elements, accumulates the
// unsigned dot product and offers it to the sink over a valid/ready handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin a computation (sampled only while idle)
//   vec_in, mat_in    upstream elements, valid one cycle after the matching pop
//   leave_vec/mat     pop requests to the upstream shift registers
//   busy, done        not idle / one-cycle pulse after the last row is accepted
//   res               result, result_valid, result_ready, row_idx
module mxv_dot_engine #(
  parameter int unsigned Size = 8,
  parameter int unsigned Cols = 8,
  parameter int unsigned Rows = 8,
  parameter int unsigned AccW = 2 * Size + $clog2(Cols)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [Size-1:0] vec_in,
  input  logic [Size-1:0] mat_in,
  output logic            leave_vec,
  output logic            leave_mat,
  output logic            busy,
  output logic            done,
  mxv_dot_engine_if.master res
);

  localparam int unsigned RowW = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned IdxW = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int unsigned CntW = $clog2(Cols + 1);

  typedef enum logic [1:0] {StIdle, StVec, StMac, StEmit} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] result_q, result_d;
  logic [RowW-1:0] row_q, row_d;
  logic            done_q, done_d;
  logic [Size-1:0] vec_buf_q [Cols];
  logic [Size-1:0] vec_buf_d [Cols];

  // Elements arrive one cycle after their pop, so cycle cnt consumes element cnt-1.
  logic [IdxW-1:0] prev_idx;
  logic [AccW-1:0] prod;

  assign prev_idx = IdxW'(cnt_q - CntW'(1));
  assign prod     = AccW'(mat_in) * AccW'(vec_buf_q[prev_idx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < int'(Cols); i++) vec_buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      row_q     <= row_d;
      done_q    <= done_d;
      vec_buf_q <= vec_buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    row_d     = row_q;
    done_d    = 1'b0;
    vec_buf_d = vec_buf_q;
    leave_vec = 1'b0;
    leave_mat = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StVec;
          cnt_d   = '0;
          row_d   = '0;
        end
      end

      StVec: begin
        leave_vec = 1'b1;
        if (cnt_q != '0) vec_buf_d[prev_idx] = vec_in;
        if (cnt_q == CntW'(Cols - 1)) begin
          cnt_d   = '0;
          state_d = StMac;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StMac: begin
        leave_mat = (cnt_q != CntW'(Cols));
        if (cnt_q == '0) begin
          acc_d = '0;
          // The last vector element lands here; only row 0 follows the vector fetch.
          if (row_q == '0) vec_buf_d[IdxW'(Cols - 1)] = vec_in;
        end else begin
          acc_d = acc_q + prod;
        end
        if (cnt_q == CntW'(Cols)) begin
          result_d = acc_q + prod;
          cnt_d    = '0;
          state_d  = StEmit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StEmit: begin
        if (res.result_ready) begin
          if (row_q == RowW'(Rows - 1)) begin
            done_d  = 1'b1;
            row_d   = '0;
            state_d = StIdle;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StMac;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign res.result       = result_q;
  assign res.result_valid = (state_q == StEmit);
  assign res.row_idx      = row_q;
  assign busy             = (state_q != StIdle);
  assign done             = done_q;

endmodule

// File: doc/mxv_dot_engine.md
Name: mxv_dot_engine

Overview:
- Compute stage directly downstream of the matrix and vector byte-shift registers in the MxV datapath.
- Pops Cols vector elements once and keeps them in a local buffer.
- Then, for each of Rows matrix rows, pops Cols matrix elements and accumulates the unsigned dot product.
- Emits one result per row over a valid/ready handshake to the result sink.

Parameters:
- Size, 8, element width in bits (matrix and vector).
- Cols, 8, elements per row (= vector length).
- Rows, 8, matrix rows per computation.
- AccW, 2*Size+$clog2(Cols) (19), result width; overflow impossible.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  begin computation; sampled only in IDLE
- vec_in  in  Size  vector element from upstream, valid 1 cycle after leave_vec
- mat_in  in  Size  matrix element from upstream, valid 1 cycle after leave_mat
- leave_vec  out  1  pop request to vector register, one element per high cycle
- leave_mat  out  1  pop request to matrix register, one element per high cycle
- result  out  AccW  dot product of current row
- result_valid  out  1  result holds a valid row result
- result_ready  in  1  sink accepts result
- row_idx  out  $clog2(Rows)  row index of current/emitted result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE; all outputs 0; accumulator, counters and vec_buf cleared.
  - Reset mid-operation aborts the computation: no done pulse, partial results discarded.
- Element ordering: k-th pop = element k; upstream is responsible for delivering elements in index order.
- IDLE:
  - start=1 -> VEC, row_idx=0, elem counter=0.
  - start while busy is ignored.
- VEC (Cols cycles, c=0..Cols-1):
  - leave_vec=1 every cycle.
  - vec_in captured into vec_buf[c] at cycle c+1.
  - After cycle Cols-1 -> MAC.
- MAC (Cols+1 cycles, j=0..Cols):
  - leave_mat=1 for j=0..Cols-1, 0 at j=Cols.
  - At j=0: acc cleared; vec_buf[Cols-1] captured (last vector lag).
  - At j=1..Cols: acc += mat_in * vec_buf[j-1], unsigned, full width AccW.
  - At j=Cols: result <= final sum, state -> EMIT.
- EMIT:
  - result_valid=1; result and row_idx held stable; no leave pulses.
  - Handshake = result_valid & result_ready.
  - On handshake with row_idx<Rows-1: row_idx++, -> MAC next cycle, result_valid=0.
  - On handshake with row_idx=Rows-1: done=1 for 1 cycle, -> IDLE, result_valid=0, row_idx=0.
  - result_ready while result_valid=0 has no effect.
- Latency: start at cycle 0 -> leave_vec high cycles 1..Cols, MAC cycles Cols+1..2Cols+1, first result_valid at cycle 2Cols+2 (18 for defaults). With result_ready tied high, each subsequent row takes Cols+2 cycles.
- leave_vec and leave_mat are never high in the same cycle.
- Vector is fetched once per start; vec_buf is reused for all rows.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> all outputs 0, busy=0; start sampled on the first cycle after reset releases.
- Timing, all-ones vector, row r elements = r+1, result_ready=1: start at cycle 0 -> leave_vec high cycles 1..8, first result_valid at cycle 18, results 8,16,24,...,64 with row_idx 0..7, done pulse in the cycle after the 8th accept.
- Max values, all elements 255 -> every result = 520200, no wrap (fits 19 bits).
- Backpressure: result_ready low 5 cycles on row 2 -> result_valid stays high, result and row_idx stable, leave_mat/leave_vec 0, remaining rows correct afterwards.
- Reset asserted during MAC of row 3 -> next cycle all outputs 0, no done; a fresh start recomputes from row 0 and refetches the vector.
- start pulsed during VEC and EMIT -> ignored; exactly one done, 8 results total.
